// File: rtl/syn_fgyrus_pcm_rd_seq.sv
// -----------------------------------------------------------------------------
// syn_fgyrus_pcm_rd_seq
//
// Copies one PCM frame from the acortex PCM RAM into the local fgyrus sample
// buffer. A rising edge on pcm_rdy requests a frame. The frame starts once the
// downstream FFT is no longer busy. Every address 0..2**ADDR_W-1 is read once,
// in ascending order. Each word is written RD_LAT cycles after its address was
// issued.
//
// Optional build macro:
//   SYN_FGYRUS_PCM_MONO_EN - when defined, each written word is the mono mix
//                            (left+right)>>>1, sign-extended to DATA_W.
//                            When undefined, the PCM word is written unchanged.
//                            Timing is the same in both builds.
//
// Parameters:
//   ADDR_W - PCM RAM / sample buffer address width
//   DATA_W - PCM word width, {left, right} halves
//   RD_LAT - PCM RAM read latency in clk cycles (1..3)
//
// Ports:
//   clk          - sole clock, rising edge
//   rst          - synchronous active-high reset
//   pcm_rdy      - frame-available level from acortex (rising edge = request)
//   pcm_rd_addr  - PCM RAM read address
//   pcm_data     - PCM RAM read data, RD_LAT cycles after its address
//   fft_busy     - FFT is using the sample buffer; blocks a new frame start
//   smp_wr_en    - sample buffer write strobe
//   smp_wr_addr  - sample buffer write address
//   smp_wr_data  - sample buffer write data
//   frame_done   - one-cycle pulse after the last sample is written
//   overrun      - one-cycle pulse when a frame request is dropped
//   busy         - sequencer is not idle
// -----------------------------------------------------------------------------
module syn_fgyrus_pcm_rd_seq #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pcm_rdy,
   output logic [ADDR_W-1:0] pcm_rd_addr,
   input  logic [DATA_W-1:0] pcm_data,
   input  logic              fft_busy,
   output logic              smp_wr_en,
   output logic [ADDR_W-1:0] smp_wr_addr,
   output logic [DATA_W-1:0] smp_wr_data,
   output logic              frame_done,
   output logic              overrun,
   output logic              busy
);

   localparam int                HALF_W     = DATA_W / 2;
   localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
   localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              pcm_rdy_d;
   logic              rdy_mask;
   logic              pending;
   logic              rise;
   logic              start;
   logic [1:0]        drain_cnt;
   logic              vld_p  [RD_LAT];
   logic [ADDR_W-1:0] addr_p [RD_LAT];

`ifdef SYN_FGYRUS_PCM_MONO_EN
   // The 17-bit sum cannot overflow. The arithmetic shift floors toward -inf.
   // The shifted result fits in HALF_W bits, so its bit HALF_W-1 is the sign.
   function automatic logic [DATA_W-1:0] mono_mix(input logic [DATA_W-1:0] w);
      logic signed [HALF_W-1:0] left;
      logic signed [HALF_W-1:0] right;
      logic signed [HALF_W:0]   sum;
      logic signed [HALF_W:0]   half;
      left  = w[DATA_W-1:HALF_W];
      right = w[HALF_W-1:0];
      sum   = {left[HALF_W-1], left} + {right[HALF_W-1], right};
      half  = sum >>> 1;
      return {{(DATA_W-HALF_W){half[HALF_W-1]}}, half[HALF_W-1:0]};
   endfunction
`endif

   // rdy_mask holds off a pcm_rdy level that was already high at reset
   // release. That level is not counted as a rise until pcm_rdy has gone low.
   always_ff @(posedge clk) begin
      if (rst) begin
         pcm_rdy_d <= 1'b0;
         rdy_mask  <= pcm_rdy;
      end else begin
         pcm_rdy_d <= pcm_rdy;
         rdy_mask  <= rdy_mask & pcm_rdy;
      end
   end

   always_comb begin
      rise  = pcm_rdy & ~pcm_rdy_d & ~rdy_mask;
      start = (state == IDLE) && pending && !fft_busy;
   end

   // A rise in the start cycle re-arms the request. A rise that lands on an
   // already-pending request while a frame runs is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= rise && pending && (state != IDLE);
         if (start)
            pending <= rise;
         else if (rise)
            pending <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = READ;
         READ:    if (pcm_rd_addr == LAST_ADDR) state_nxt = DRAIN;
         DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The address stops at LAST_ADDR and holds its value outside READ.
   always_ff @(posedge clk) begin
      if (rst) begin
         pcm_rd_addr <= '0;
         drain_cnt   <= '0;
      end else begin
         if (start)
            pcm_rd_addr <= '0;
         else if (state == READ && pcm_rd_addr != LAST_ADDR)
            pcm_rd_addr <= pcm_rd_addr + ADDR_W'(1);
         if (state == DRAIN)
            drain_cnt <= drain_cnt + 2'd1;
         else
            drain_cnt <= '0;
      end
   end

   // p0: address issued this cycle; p[RD_LAT-1]: address whose data is on pcm_data
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            vld_p[i]  <= 1'b0;
            addr_p[i] <= '0;
         end
      end else begin
         vld_p[0]  <= (state == READ);
         addr_p[0] <= pcm_rd_addr;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_p[i]  <= vld_p[i-1];
            addr_p[i] <= addr_p[i-1];
         end
      end
   end

   always_comb begin
      busy        = (state != IDLE);
      frame_done  = (state == DONE);
      smp_wr_en   = vld_p[RD_LAT-1];
      smp_wr_addr = addr_p[RD_LAT-1];
      smp_wr_data = '0;
      if (vld_p[RD_LAT-1]) begin
`ifdef SYN_FGYRUS_PCM_MONO_EN
         smp_wr_data = mono_mix(pcm_data);
`else
         smp_wr_data = pcm_data;
`endif
      end
   end

endmodule

// File: tb/tb_syn_fgyrus_pcm_rd_seq.sv
// -----------------------------------------------------------------------------
// tb_syn_fgyrus_pcm_rd_seq
//
// Testbench for syn_fgyrus_pcm_rd_seq. One instance runs with RD_LAT=1 and one
// with RD_LAT=3. Both share the same control inputs. Each instance has its own
// PCM RAM model at the matching latency. Expected writes are queued per
// instance and popped as the instance writes.
// -----------------------------------------------------------------------------
module tb_syn_fgyrus_pcm_rd_seq;

   localparam int AW = 7;
   localparam int DW = 32;
   localparam int N  = 1 << AW;
   localparam int NV = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pcm_rdy = 1'b0;
   logic          fft_busy = 1'b0;
   logic [AW-1:0] rd_addr1, rd_addr3, wr_addr1, wr_addr3;
   logic [DW-1:0] data1, data3, wr_data1, wr_data3;
   logic          wr_en1, wr_en3, done1, done3, ovr1, ovr3, busy1, busy3;

   always #5 clk = ~clk;

   syn_fgyrus_pcm_rd_seq #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .pcm_rdy(pcm_rdy), .pcm_rd_addr(rd_addr1),
      .pcm_data(data1), .fft_busy(fft_busy), .smp_wr_en(wr_en1),
      .smp_wr_addr(wr_addr1), .smp_wr_data(wr_data1), .frame_done(done1),
      .overrun(ovr1), .busy(busy1));

   syn_fgyrus_pcm_rd_seq #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .pcm_rdy(pcm_rdy), .pcm_rd_addr(rd_addr3),
      .pcm_data(data3), .fft_busy(fft_busy), .smp_wr_en(wr_en3),
      .smp_wr_addr(wr_addr3), .smp_wr_data(wr_data3), .frame_done(done3),
      .overrun(ovr3), .busy(busy3));

   // PCM RAM models at latency 1 and latency 3.
   logic [DW-1:0] mem [N];
   logic [DW-1:0] d3_a, d3_b;
   always @(posedge clk) begin
      data1 <= mem[rd_addr1];
      d3_a  <= mem[rd_addr3];
      d3_b  <= d3_a;
      data3 <= d3_b;
   end

   typedef struct packed {
      logic [DW-1:0] din;
      logic [DW-1:0] exp_pass;
      logic [DW-1:0] exp_mono;
   } vec_t;
   vec_t vecs [NV];

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;
   wr_t q1[$];
   wr_t q3[$];

   int checks = 0;
   int failures = 0;
   int wr_cnt1 = 0, wr_cnt3 = 0, done_cnt1 = 0, done_cnt3 = 0, ovr_cnt1 = 0, ovr_cnt3 = 0;
   logic [DW-1:0] cap1 [N];
   logic [DW-1:0] cap3 [N];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Reference model: mono mix computed with integer arithmetic.
   function automatic logic [DW-1:0] model(input logic [DW-1:0] d);
`ifdef SYN_FGYRUS_PCM_MONO_EN
      int l, r, s;
      l = int'($signed(d[31:16]));
      r = int'($signed(d[15:0]));
      s = (l + r) >>> 1;
      return DW'(s);
`else
      return d;
`endif
   endfunction

   function automatic logic [DW-1:0] exp_of(input int i);
      if (i < NV) begin
`ifdef SYN_FGYRUS_PCM_MONO_EN
         return vecs[i].exp_mono;
`else
         return vecs[i].exp_pass;
`endif
      end
      return model(mem[i]);
   endfunction

   task automatic expect_frame();
      for (int i = 0; i < N; i++) begin
         q1.push_back({AW'(i), exp_of(i)});
         q3.push_back({AW'(i), exp_of(i)});
      end
   endtask

   task automatic sb_pop(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_t e;
      checks++;
      if ((id == 1 && q1.size() == 0) || (id == 3 && q3.size() == 0)) begin
         failures++;
         $display("FAIL sb%0d_unexpected_write actual addr=%0d data=0x%0h required=no write", id, a, d);
      end else begin
         if (id == 1) e = q1.pop_front();
         else         e = q3.pop_front();
         if (a !== e.addr || d !== e.data) begin
            failures++;
            $display("FAIL sb%0d_write actual addr=%0d data=0x%0h required addr=%0d data=0x%0h",
                     id, a, d, e.addr, e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      if (done1) done_cnt1++;
      if (done3) done_cnt3++;
      if (ovr1)  ovr_cnt1++;
      if (ovr3)  ovr_cnt3++;
      if (wr_en1) begin
         wr_cnt1++;
         cap1[wr_addr1] = wr_data1;
         sb_pop(1, wr_addr1, wr_data1);
      end
      if (wr_en3) begin
         wr_cnt3++;
         cap3[wr_addr3] = wr_data3;
         sb_pop(3, wr_addr3, wr_data3);
      end
   end

   // n = 0 at the first rising edge after the call. The task records the first
   // edge after which frame_done is seen, separately for each instance.
   task automatic wait_done(input int exp1, input int exp3, input int busy_at, input string tag);
      int n = -1, n1 = -1, n3 = -1;
      while ((n1 < 0 || n3 < 0) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
         if (done1 && n1 < 0) n1 = n;
         if (done3 && n3 < 0) n3 = n;
         if (n == busy_at) fft_busy = 1'b1;
      end
      chk({tag, "_done_lat_rd1"}, 64'(n1), 64'(exp1));
      chk({tag, "_done_lat_rd3"}, 64'(n3), 64'(exp3));
   endtask

   task automatic pulse_rdy();
      @(negedge clk) pcm_rdy = 1'b1;
      @(negedge clk) pcm_rdy = 1'b0;
   endtask

   task automatic wait_frames(input int k, input int d1_0, input int d3_0);
      int n = 0;
      while ((done_cnt1 - d1_0 < k || done_cnt3 - d3_0 < k) && n < 1200) begin
         @(negedge clk);
         n++;
      end
      repeat (8) @(negedge clk);
   endtask

   initial begin
      int w1, w3, d1, d3, o1, o3, k;

      vecs[0] = {32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h0000_7FFF};
      vecs[1] = {32'h8000_8000, 32'h8000_8000, 32'hFFFF_8000};
      vecs[2] = {32'h0001_FFFF, 32'h0001_FFFF, 32'h0000_0000};
      vecs[3] = {32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
      vecs[4] = {32'h1234_5678, 32'h1234_5678, 32'h0000_3456};
      vecs[5] = {32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
      vecs[6] = {32'hFFFF_0001, 32'hFFFF_0001, 32'h0000_0000};
      vecs[7] = {32'h8000_7FFF, 32'h8000_7FFF, 32'hFFFF_FFFF};
      for (int i = 0; i < N; i++) mem[i] = (i < NV) ? vecs[i].din : $urandom;

      // Reset with pcm_rdy held high, then release while pcm_rdy stays high.
      rst = 1'b1;
      pcm_rdy = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_outputs_rd1", {busy1, done1, ovr1, wr_en1, rd_addr1, wr_addr1, wr_data1}, 64'd0);
      chk("rst_outputs_rd3", {busy3, done3, ovr3, wr_en3, rd_addr3, wr_addr3, wr_data3}, 64'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("held_rdy_no_start", {busy1, busy3, wr_en1, wr_en3}, 64'd0);
      pcm_rdy = 1'b0;
      repeat (3) @(negedge clk);

      // Basic frame: latency and table contents.
      w1 = wr_cnt1; w3 = wr_cnt3; d1 = done_cnt1; d3 = done_cnt3;
      expect_frame();
      @(negedge clk) pcm_rdy = 1'b1;
      wait_done(130, 132, -1, "frame1");
      repeat (5) @(negedge clk);
      pcm_rdy = 1'b0;
      chk("frame1_writes_rd1", 64'(wr_cnt1 - w1), 64'd128);
      chk("frame1_writes_rd3", 64'(wr_cnt3 - w3), 64'd128);
      chk("frame1_done_pulses", 64'({done_cnt1 - d1, done_cnt3 - d3}), 64'({32'd1, 32'd1}));
      chk("rd_addr_hold", {rd_addr1, rd_addr3, busy1, busy3}, {7'd127, 7'd127, 2'b00});
      for (int i = 0; i < NV; i++) begin
         chk($sformatf("vec%0d_rd1", i), cap1[i], exp_of(i));
         chk($sformatf("vec%0d_rd3", i), cap3[i], exp_of(i));
      end

      // fft_busy blocks the start. A later fft_busy pulse mid-frame does not stall it.
      w1 = wr_cnt1; d1 = done_cnt1;
      fft_busy = 1'b1;
      repeat (20) @(negedge clk);
      pcm_rdy = 1'b1;
      repeat (29) @(negedge clk);
      chk("fft_busy_holds_idle", {busy1, busy3, 32'(wr_cnt1 - w1)}, 64'd0);
      expect_frame();
      @(negedge clk) fft_busy = 1'b0;
      wait_done(129, 131, 50, "fftb");
      repeat (5) @(negedge clk);
      fft_busy = 1'b0;
      pcm_rdy = 1'b0;
      chk("fftb_writes_done", {32'(wr_cnt1 - w1), 32'(done_cnt1 - d1)}, {32'd128, 32'd1});

      // Three rises: one starts a frame, one is pending, one is dropped.
      w1 = wr_cnt1; w3 = wr_cnt3; d1 = done_cnt1; d3 = done_cnt3; o1 = ovr_cnt1; o3 = ovr_cnt3;
      expect_frame();
      expect_frame();
      pulse_rdy();
      repeat (20) @(negedge clk);
      pulse_rdy();
      repeat (20) @(negedge clk);
      pulse_rdy();
      wait_frames(2, d1, d3);
      chk("ovr_pulses", 64'({ovr_cnt1 - o1, ovr_cnt3 - o3}), 64'({32'd1, 32'd1}));
      chk("ovr_done_pulses", 64'({done_cnt1 - d1, done_cnt3 - d3}), 64'({32'd2, 32'd2}));
      chk("ovr_writes", 64'({wr_cnt1 - w1, wr_cnt3 - w3}), 64'({32'd256, 32'd256}));

      // Reset at read address 60 aborts the frame.
      w1 = wr_cnt1; w3 = wr_cnt3; d1 = done_cnt1; d3 = done_cnt3;
      expect_frame();
      pulse_rdy();
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (rd_addr1 != 7'd60 && k < 300);
      chk("rst_mid_reach_addr60", rd_addr1, 64'd60);
      rst = 1'b1;
      @(posedge clk);
      #1;
      q1.delete();
      q3.delete();
      @(negedge clk);
      chk("rst_mid_outputs", {wr_en1, wr_en3, busy1, busy3, done1, done3}, 64'd0);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      chk("rst_mid_no_done", 64'({done_cnt1 - d1, done_cnt3 - d3}), 64'd0);
      chk("rst_mid_writes", 64'({wr_cnt1 - w1, wr_cnt3 - w3}), 64'({32'd60, 32'd58}));

      // The next frame after the abort starts again from address 0.
      w1 = wr_cnt1; w3 = wr_cnt3; d1 = done_cnt1; d3 = done_cnt3;
      expect_frame();
      pulse_rdy();
      wait_frames(1, d1, d3);
      chk("post_rst_frame_writes", 64'({wr_cnt1 - w1, wr_cnt3 - w3}), 64'({32'd128, 32'd128}));
      chk("post_rst_frame_done", 64'({done_cnt1 - d1, done_cnt3 - d3}), 64'({32'd1, 32'd1}));
      chk("sb_queues_empty", 64'({q1.size(), q3.size()}), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
